// File: rtl/fm_audio_decim.sv
// fm_audio_decim: boxcar decimation by 2^DECIM_LOG2, then first-order IIR de-emphasis.
// Defining FM_AUDIO_DCBLOCK_EN inserts a DC-blocking stage (DCB) between the IIR and the output.
module fm_audio_decim #(
    parameter int BITS_IN      = 16,
    parameter int BITS_OUT     = 16,
    parameter int DECIM_LOG2   = 3,
    parameter int DEEMPH_SHIFT = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic signed [BITS_IN-1:0]  demod_in,
    input  logic                       in_tick,
    output logic signed [BITS_OUT-1:0] audio_out,
    output logic                       out_tick,
    output logic                       overrun
);

    localparam int AW = BITS_IN + DECIM_LOG2;
    localparam int YW = BITS_IN + DEEMPH_SHIFT;
    localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << DECIM_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        OUT  = 2'd2
`ifdef FM_AUDIO_DCBLOCK_EN
        , DCB = 2'd3
`endif
    } state_t;

    state_t                       state_q;
    logic signed [AW-1:0]         acc_q, acc_d;
    logic        [CW-1:0]         cnt_q;
    logic signed [BITS_IN-1:0]    dec_q, dec_d;
    logic signed [YW-1:0]         y_q, y_d;
    logic signed [BITS_IN-1:0]    v_d;
    logic signed [BITS_IN-1:0]    src_d;
    logic signed [BITS_OUT-1:0]   audio_q, audio_d;
    logic                         tick_q;
    logic                         ovr_q;
    logic                         wrap;

`ifdef FM_AUDIO_DCBLOCK_EN
    localparam int DW = BITS_IN + 10;
    localparam int EW = BITS_IN + 2;
    localparam logic signed [EW-1:0] SAT_HI = {3'b000, {(BITS_IN-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {3'b111, {(BITS_IN-1){1'b0}}};

    logic signed [DW-1:0]      dc_q, dc_d;
    logic signed [BITS_IN-1:0] dcs_d;
    logic signed [EW-1:0]      e_full;
    logic signed [BITS_IN-1:0] e_q, e_d;
`endif

    assign wrap = in_tick && (cnt_q == CNT_MAX);

    always_comb begin
        acc_d = acc_q + AW'(demod_in);
        dec_d = BITS_IN'(acc_d >>> DECIM_LOG2);
        y_d   = y_q + YW'(dec_q) - (y_q >>> DEEMPH_SHIFT);
        v_d   = BITS_IN'(y_q >>> DEEMPH_SHIFT);
`ifdef FM_AUDIO_DCBLOCK_EN
        dcs_d  = BITS_IN'(dc_q >>> 10);
        e_full = EW'(v_d) - EW'(dcs_d);
        dc_d   = dc_q + DW'(e_full);
        // e can reach twice the input range; clamp before the output MSB pick
        if (e_full > SAT_HI) begin
            e_d = BITS_IN'(SAT_HI);
        end else if (e_full < SAT_LO) begin
            e_d = BITS_IN'(SAT_LO);
        end else begin
            e_d = BITS_IN'(e_full);
        end
        src_d = e_q;
`else
        src_d = v_d;
`endif
        audio_d = BITS_OUT'(src_d >>> (BITS_IN - BITS_OUT));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= '0;
            y_q     <= '0;
            audio_q <= '0;
            tick_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef FM_AUDIO_DCBLOCK_EN
            dc_q    <= '0;
            e_q     <= '0;
`endif
        end else begin
            tick_q <= 1'b0;

            // The accumulator runs independently of the FSM; a busy FSM only drops the mean
            if (in_tick) begin
                if (cnt_q == CNT_MAX) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (state_q == IDLE) begin
                        dec_q <= dec_d;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (wrap) state_q <= UPD;
                end
                UPD: begin
                    y_q <= y_d;
`ifdef FM_AUDIO_DCBLOCK_EN
                    state_q <= DCB;
`else
                    state_q <= OUT;
`endif
                end
`ifdef FM_AUDIO_DCBLOCK_EN
                DCB: begin
                    dc_q    <= dc_d;
                    e_q     <= e_d;
                    state_q <= OUT;
                end
`endif
                OUT: begin
                    audio_q <= audio_d;
                    tick_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign audio_out = audio_q;
    assign out_tick  = tick_q;
    assign overrun   = ovr_q;

endmodule
